dsp_mixer: RTL and testbench
============================

Name: dsp_mixer

Overview:
Downstream of the per-channel sound stage. Accumulates the 8 channels' `chsound_l`/`chsound_r` into main and echo-send sums over one 32 kHz sample period. It then applies master volume, adds the volume-scaled echo return, applies mute, and presents one 16-bit stereo sample per period. The echo-send sums go to the echo/FIR stage.

Parameters:
- NUM_CH, 8, number of channels accumulated per frame (channel index width is 3 bits).

Ports:
- clk  in  1  10.24MHz system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  clock enable; all state updates are qualified by cpu_en=1
- exe_32khz  in  1  frame-start strobe; clears the accumulators and starts a new frame
- ch_valid  in  1  channel contribution valid this cpu_en cycle
- ch_index  in  3  channel number of the current contribution
- chsound_l  in  15  signed channel output, left
- chsound_r  in  15  signed channel output, right
- eon  in  8  echo-enable per channel (EON register)
- mix_start  in  1  all channels delivered; begin final mix
- mvol_l  in  8  signed master volume, left
- mvol_r  in  8  signed master volume, right
- evol_l  in  8  signed echo-return volume, left
- evol_r  in  8  signed echo-return volume, right
- echo_in_l  in  16  signed echo-return sample, left
- echo_in_r  in  16  signed echo-return sample, right
- mute  in  1  FLG bit 6; forces the output to zero
- echo_send_l  out  16  signed echo-send sum, left
- echo_send_r  out  16  signed echo-send sum, right
- sound_l  out  16  signed final sample, left
- sound_r  out  16  signed final sample, right
- sound_valid  out  1  one-clk pulse (coincident with cpu_en) when sound_l/r update

Behaviour:
- Reset: state=IDLE. All accumulators, `seen`, `echo_send_*`, `sound_*` are 0. `sound_valid`=0.
- States: IDLE, ACCUM, MAIN, ECHO. All transitions occur only on clk edges with cpu_en=1.
- exe_32khz=1 (any state):
  - main_acc_l/r, echo_acc_l/r cleared; seen=0; next state ACCUM.
  - Any in-flight MAIN/ECHO result is discarded; sound_* keep their previous value.
- ACCUM, ch_valid=1 and seen[ch_index]=0:
  - main_acc += sext16(chsound); if eon[ch_index], echo_acc += sext16(chsound); seen[ch_index] set.
- ACCUM, ch_valid=1 and seen[ch_index]=1: duplicate, ignored entirely.
- exe_32khz and ch_valid in the same cycle: clear and add happen together. Accumulator loads sext16(chsound) (or 0 for echo_acc if eon bit clear). seen = one-hot(ch_index).
- Addition: 17-bit signed sum, then saturate to [-32768, 32767]. Saturation is applied after every add, so the result is order-dependent.
- ACCUM, mix_start=1 (and exe_32khz=0):
  - echo_send_l/r <= echo_acc_l/r; next state MAIN.
  - If ch_valid is also set that cycle, the contribution is added first and the latched value includes it.
- MAIN: main_l/r <= sat16((main_acc * mvol) >>> 7). 16x8 signed product is 24 bits; arithmetic shift. Next state ECHO.
- ECHO:
  - e = sat16((echo_in * evol) >>> 7); sound_l/r <= mute ? 0 : sat16(main + e).
  - sound_valid=1 for this single clk; next state IDLE.
- Latency: mix_start accepted at cpu_en edge N; sound_valid at cpu_en edge N+2.
- Ignored inputs:
  - ch_valid and mix_start are ignored in IDLE, MAIN and ECHO.
  - mix_start in ACCUM with seen≠all-ones is still honoured; missing channels contribute 0.
- cpu_en=0: all registers hold; sound_valid=0.
- echo_send_* hold between frames; updated only at mix_start acceptance.

Test Plan:
- Reset then idle 64 clk -> all outputs 0, sound_valid never asserted.
- Saturation: frame with ch0..ch2 chsound_l=16383 (0x3FFF), mvol_l=0x7F, evol=0, mix_start -> main_acc 32767; sound_l=32511 exactly two cpu_en edges after mix_start; sound_valid one clk.
- Negative-extreme volume: main_acc=-32768 (three channels of -16384), mvol_l=0x80 -> product>>>7=32768 -> sound_l=32767. Same with main_acc=32767 -> sound_l=-32767.
- Echo: ch0 chsound=1000 with eon[0]=1, ch1=500 with eon[1]=0; mvol=0x40, echo_in=2000, evol=0x40 -> echo_send=1000, sound=750+1000=1750. With mute=1 -> sound=0 but echo_send=1000.
- Duplicate/collision:
  - ch3 sent twice with 100 -> sum 100 only.
  - exe_32khz coincident with ch_valid ch5=-200 -> new frame acc=-200.
  - exe_32khz during MAIN -> no sound_valid, sound_* unchanged.
- Mid-frame reset after 4 channels -> state IDLE, accumulators 0; next frame of 8×10 -> sound=80×mvol>>>7.

Source files
------------

// File: rtl/dsp_mixer_if.sv
// Channel-contribution and stereo-sample bus between the voice stage, the mixer and the echo/FIR stage.
interface dsp_mixer_if;
  logic                cpu_en;
  logic                exe_32khz;
  logic                ch_valid;
  logic [2:0]          ch_index;
  logic signed [14:0]  chsound_l;
  logic signed [14:0]  chsound_r;
  logic [7:0]          eon;
  logic                mix_start;
  logic signed [7:0]   mvol_l;
  logic signed [7:0]   mvol_r;
  logic signed [7:0]   evol_l;
  logic signed [7:0]   evol_r;
  logic signed [15:0]  echo_in_l;
  logic signed [15:0]  echo_in_r;
  logic                mute;
  logic signed [15:0]  echo_send_l;
  logic signed [15:0]  echo_send_r;
  logic signed [15:0]  sound_l;
  logic signed [15:0]  sound_r;
  logic                sound_valid;

  modport master (
    output cpu_en, exe_32khz, ch_valid, ch_index, chsound_l, chsound_r, eon,
           mix_start, mvol_l, mvol_r, evol_l, evol_r, echo_in_l, echo_in_r, mute,
    input  echo_send_l, echo_send_r, sound_l, sound_r, sound_valid
  );

  modport slave (
    input  cpu_en, exe_32khz, ch_valid, ch_index, chsound_l, chsound_r, eon,
           mix_start, mvol_l, mvol_r, evol_l, evol_r, echo_in_l, echo_in_r, mute,
    output echo_send_l, echo_send_r, sound_l, sound_r, sound_valid
  );
endinterface

// File: rtl/dsp_mixer.sv
// Per-frame channel accumulator and final stereo mixer: main/echo-send sums, master volume,
// echo return and mute, producing one 16-bit stereo sample per 32 kHz period.
module dsp_mixer #(
  parameter int NUM_CH = 8
) (
  input  logic         clk,
  input  logic         reset,
  dsp_mixer_if.slave   mix
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W + 1;

  localparam logic signed [PROD_W-1:0] MAX_V = 32767;
  localparam logic signed [PROD_W-1:0] MIN_V = -32768;

  typedef enum logic [1:0] {IDLE, ACCUM, MAIN, ECHO} state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [PROD_W-1:0] x);
    if (x > MAX_V)      return MAX_V[DATA_W-1:0];
    else if (x < MIN_V) return MIN_V[DATA_W-1:0];
    else                return x[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] ea;
    logic signed [PROD_W-1:0] eb;
    ea = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    eb = {{(PROD_W-DATA_W){b[DATA_W-1]}}, b};
    return sat16(ea + eb);
  endfunction

  // Q1.7 volume: the product is scaled back by 2^7 with an arithmetic (flooring) shift.
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [COEF_W-1:0] v);
    logic signed [PROD_W-1:0] ea;
    logic signed [PROD_W-1:0] ev;
    logic signed [PROD_W-1:0] p;
    ea = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    ev = {{(PROD_W-COEF_W){v[COEF_W-1]}}, v};
    p  = ea * ev;
    return sat16(p >>> 7);
  endfunction

  state_t                    state;
  logic [NUM_CH-1:0]         seen;
  logic signed [DATA_W-1:0]  main_acc_l, main_acc_r;
  logic signed [DATA_W-1:0]  echo_acc_l, echo_acc_r;
  logic signed [DATA_W-1:0]  echo_send_l_p0, echo_send_r_p0;
  logic signed [DATA_W-1:0]  main_l_p1, main_r_p1;
  logic signed [DATA_W-1:0]  sound_l_p2, sound_r_p2;
  logic                      vld_p2;

  logic signed [DATA_W-1:0]  ch_l, ch_r;
  logic signed [DATA_W-1:0]  main_base_l, main_base_r, echo_base_l, echo_base_r;
  logic signed [DATA_W-1:0]  main_nxt_l, main_nxt_r, echo_nxt_l, echo_nxt_r;
  logic [NUM_CH-1:0]         seen_nxt;
  logic [NUM_CH-1:0]         ch_onehot;
  logic                      take;

  // A frame start clears and may add in the same cycle, so the add is built on a cleared base.
  always_comb begin
    ch_l        = {mix.chsound_l[14], mix.chsound_l};
    ch_r        = {mix.chsound_r[14], mix.chsound_r};
    main_base_l = mix.exe_32khz ? '0 : main_acc_l;
    main_base_r = mix.exe_32khz ? '0 : main_acc_r;
    echo_base_l = mix.exe_32khz ? '0 : echo_acc_l;
    echo_base_r = mix.exe_32khz ? '0 : echo_acc_r;
    ch_onehot   = '0;
    ch_onehot[mix.ch_index] = 1'b1;
    take = mix.ch_valid &&
           (mix.exe_32khz || ((state == ACCUM) && !seen[mix.ch_index]));
    main_nxt_l = take ? add_sat(main_base_l, ch_l) : main_base_l;
    main_nxt_r = take ? add_sat(main_base_r, ch_r) : main_base_r;
    echo_nxt_l = (take && mix.eon[mix.ch_index]) ? add_sat(echo_base_l, ch_l) : echo_base_l;
    echo_nxt_r = (take && mix.eon[mix.ch_index]) ? add_sat(echo_base_r, ch_r) : echo_base_r;
    seen_nxt   = (mix.exe_32khz ? '0 : seen) | (take ? ch_onehot : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      seen           <= '0;
      main_acc_l     <= '0;
      main_acc_r     <= '0;
      echo_acc_l     <= '0;
      echo_acc_r     <= '0;
      echo_send_l_p0 <= '0;
      echo_send_r_p0 <= '0;
      main_l_p1      <= '0;
      main_r_p1      <= '0;
      sound_l_p2     <= '0;
      sound_r_p2     <= '0;
      vld_p2         <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (mix.cpu_en) begin
        main_acc_l <= main_nxt_l;
        main_acc_r <= main_nxt_r;
        echo_acc_l <= echo_nxt_l;
        echo_acc_r <= echo_nxt_r;
        seen       <= seen_nxt;
        if (mix.exe_32khz) begin
          state <= ACCUM;
        end else begin
          unique case (state)
            IDLE: state <= IDLE;
            // p0: echo-send latch, including a contribution arriving with mix_start
            ACCUM: begin
              if (mix.mix_start) begin
                echo_send_l_p0 <= echo_nxt_l;
                echo_send_r_p0 <= echo_nxt_r;
                state          <= MAIN;
              end
            end
            // p1: master volume
            MAIN: begin
              main_l_p1 <= scale(main_acc_l, mix.mvol_l);
              main_r_p1 <= scale(main_acc_r, mix.mvol_r);
              state     <= ECHO;
            end
            // p2: echo return, mute, output sample
            ECHO: begin
              sound_l_p2 <= mix.mute ? '0 : add_sat(main_l_p1, scale(mix.echo_in_l, mix.evol_l));
              sound_r_p2 <= mix.mute ? '0 : add_sat(main_r_p1, scale(mix.echo_in_r, mix.evol_r));
              vld_p2     <= 1'b1;
              state      <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign mix.echo_send_l = echo_send_l_p0;
  assign mix.echo_send_r = echo_send_r_p0;
  assign mix.sound_l     = sound_l_p2;
  assign mix.sound_r     = sound_r_p2;
  assign mix.sound_valid = vld_p2;

endmodule

// File: tb/tb_dsp_mixer.sv
// Bench for dsp_mixer: directed frames for the corner cases plus randomized traffic against a frame-level model.
module tb_dsp_mixer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsp_mixer_if mif ();
  dsp_mixer #(.NUM_CH(8)) dut (.clk(clk), .reset(reset), .mix(mif.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // slowly changing inputs, owned by the bench
  int mvol_l, mvol_r, evol_l, evol_r, ein_l, ein_r;
  bit mute;
  bit [7:0] eon;

  // reference model: frame sums, seen set, and a countdown to the output sample
  int macc_l, macc_r, eacc_l, eacc_r;
  int send_l, send_r, mres_l, mres_r, snd_l, snd_r;
  int pend;
  bit in_frame;
  bit [7:0] seen;
  bit exp_vld;

  function automatic int clamp(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int vol(input int a, input int v);
    int p;
    p = a * v;
    return clamp(p >>> 7);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit en, input bit exe, input bit chv, input int idx,
                       input int l, input int r, input bit mx);
    exp_vld = 1'b0;
    if (reset) begin
      macc_l = 0; macc_r = 0; eacc_l = 0; eacc_r = 0;
      send_l = 0; send_r = 0; mres_l = 0; mres_r = 0; snd_l = 0; snd_r = 0;
      pend = 0; in_frame = 1'b0; seen = '0;
    end else if (en) begin
      if (exe) begin
        macc_l = 0; macc_r = 0; eacc_l = 0; eacc_r = 0;
        seen = '0; in_frame = 1'b1; pend = 0;
      end
      if (chv && in_frame && !seen[idx]) begin
        macc_l = clamp(macc_l + l);
        macc_r = clamp(macc_r + r);
        if (eon[idx]) begin
          eacc_l = clamp(eacc_l + l);
          eacc_r = clamp(eacc_r + r);
        end
        seen[idx] = 1'b1;
      end
      if (!exe && pend == 1) begin
        snd_l = mute ? 0 : clamp(mres_l + vol(ein_l, evol_l));
        snd_r = mute ? 0 : clamp(mres_r + vol(ein_r, evol_r));
        exp_vld = 1'b1;
        pend = 0;
      end else if (!exe && pend == 2) begin
        mres_l = vol(macc_l, mvol_l);
        mres_r = vol(macc_r, mvol_r);
        pend = 1;
      end else if (!exe && in_frame && mx) begin
        send_l = eacc_l;
        send_r = eacc_r;
        in_frame = 1'b0;
        pend = 2;
      end
    end
  endtask

  task automatic cyc(input bit en, input bit exe, input bit chv, input int idx,
                     input int l, input int r, input bit mx);
    mif.mvol_l = 8'(mvol_l);  mif.mvol_r = 8'(mvol_r);
    mif.evol_l = 8'(evol_l);  mif.evol_r = 8'(evol_r);
    mif.echo_in_l = 16'(ein_l); mif.echo_in_r = 16'(ein_r);
    mif.mute = mute;          mif.eon = eon;
    mif.cpu_en = en;          mif.exe_32khz = exe;
    mif.ch_valid = chv;       mif.ch_index = 3'(idx);
    mif.chsound_l = 15'(l);   mif.chsound_r = 15'(r);
    mif.mix_start = mx;
    @(posedge clk);
    #1;
    model(en, exe, chv, idx, l, r, mx);
    check("vld",    int'(mif.sound_valid), int'(exp_vld));
    check("snd_l",  int'(mif.sound_l), snd_l);
    check("snd_r",  int'(mif.sound_r), snd_r);
    check("send_l", int'(mif.echo_send_l), send_l);
    check("send_r", int'(mif.echo_send_r), send_r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_vols(input int mv, input int ev, input int ei);
    mvol_l = mv; mvol_r = mv; evol_l = ev; evol_r = ev; ein_l = ei; ein_r = ei;
  endtask

  initial begin
    set_vols(0, 0, 0);
    mute = 1'b0; eon = '0;
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check("rst_snd", int'(mif.sound_l), 0);
    idle(64);
    // stray channel/mix strobes outside a frame
    cyc(1, 0, 1, 2, 500, 500, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(3);
    check("idle_send", int'(mif.echo_send_l), 0);

    // saturating sum, with cpu_en gaps inside the two-edge latency
    set_vols(127, 0, 0);
    cyc(1, 1, 1, 0, 16383, 0, 0);
    cyc(1, 0, 1, 1, 16383, 0, 0);
    cyc(1, 0, 1, 2, 16383, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("sat_l", int'(mif.sound_l), 32511);
    check("sat_vld", int'(mif.sound_valid), 1);
    idle(2);

    // most negative volume
    set_vols(-128, 0, 0);
    cyc(1, 1, 1, 0, -16384, 0, 0);
    cyc(1, 0, 1, 1, -16384, 0, 0);
    cyc(1, 0, 1, 2, -16384, 0, 1);
    idle(2);
    check("negvol_min", int'(mif.sound_l), 32767);
    cyc(1, 1, 1, 0, 16383, 0, 0);
    cyc(1, 0, 1, 1, 16383, 0, 0);
    cyc(1, 0, 1, 2, 16383, 0, 1);
    idle(2);
    check("negvol_max", int'(mif.sound_l), -32767);

    // echo send/return, then muted
    set_vols(64, 64, 2000);
    eon = 8'b0000_0001;
    for (int m = 0; m < 2; m++) begin
      mute = (m == 1);
      cyc(1, 1, 1, 0, 1000, 1000, 0);
      cyc(1, 0, 1, 1, 500, 500, 0);
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(2);
      check("echo_snd", int'(mif.sound_l), (m == 1) ? 0 : 1750);
      check("echo_send", int'(mif.echo_send_r), 1000);
    end
    mute = 1'b0;

    // duplicate channel
    set_vols(64, 0, 0);
    eon = 8'b0000_1000;
    cyc(1, 1, 1, 3, 100, 100, 0);
    cyc(1, 0, 1, 3, 100, 100, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    check("dup_send", int'(mif.echo_send_l), 100);
    check("dup_snd", int'(mif.sound_l), 50);

    // frame start coincident with a contribution
    eon = 8'b0010_0000;
    cyc(1, 1, 1, 2, 300, 300, 0);
    cyc(1, 1, 1, 5, -200, -200, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    check("exe_ch_send", int'(mif.echo_send_l), -200);
    check("exe_ch_snd", int'(mif.sound_l), -100);

    // frame start while in MAIN discards the result
    cyc(1, 1, 1, 0, 9000, 9000, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(4);
    check("abort_snd", int'(mif.sound_l), -100);

    // reset mid-frame, then a full frame of 10s
    eon = 8'hFF;
    cyc(1, 1, 1, 0, 10, 10, 0);
    for (int c = 1; c < 4; c++) cyc(1, 0, 1, c, 10, 10, 0);
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check("mrst_send", int'(mif.echo_send_l), 0);
    cyc(1, 1, 1, 0, 10, 10, 0);
    for (int c = 1; c < 8; c++) cyc(1, 0, 1, c, 10, 10, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    check("full_snd", int'(mif.sound_l), 40);
    check("full_send", int'(mif.echo_send_l), 80);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mvol_l = int'($urandom_range(0, 255)) - 128;
        mvol_r = int'($urandom_range(0, 255)) - 128;
        evol_l = int'($urandom_range(0, 255)) - 128;
        evol_r = int'($urandom_range(0, 255)) - 128;
        ein_l  = int'($urandom_range(0, 65535)) - 32768;
        ein_r  = int'($urandom_range(0, 65535)) - 32768;
        mute   = ($urandom_range(0, 3) == 0);
        eon    = 8'($urandom);
      end
      reset = ($urandom_range(0, 699) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384,
          $urandom_range(0, 14) == 0);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b0;
        cyc(1, 1, 0, 0, 0, 0, 0);
      end
    end
    reset = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
